// File: rtl/tl_rx_cpl_axi_r_packer.sv
// Packs variable-size completion payload chunks into full-width AXI4 R beats, flushing a partial beat with RLAST at TLP end.
// Latency: chunk accept -> RVALID next cycle; 1 beat/cycle sustained; R outputs held until RREADY, which also gates chunk intake.
module tl_rx_cpl_axi_r_packer #(
    parameter int BEAT_DW          = 8,
    parameter int VALID_DATA_WIDTH = 5,
    parameter int ID_WIDTH         = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_cpl_valid,
    input  logic [VALID_DATA_WIDTH-1:0] i_cpl_valid_data,
    input  logic [BEAT_DW*32-1:0]       i_cpl_data,
    input  logic                        i_cpl_last,
    input  logic [9:0]                  i_cpl_tag,
    input  logic [2:0]                  i_cpl_status,
    output logic                        o_cpl_ready,
    output logic                        o_rvalid,
    input  logic                        i_rready,
    output logic [BEAT_DW*32-1:0]       o_rdata,
    output logic [ID_WIDTH-1:0]         o_rid,
    output logic [1:0]                  o_rresp,
    output logic                        o_rlast,
    output logic                        o_err_len
);
    localparam int DW_W = BEAT_DW * 32;
    localparam int CW   = $clog2(2 * BEAT_DW) + 1;

    typedef enum logic {ACCUM, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [DW_W-1:0]     acc_data_q, acc_data_d;
    logic [CW-1:0]       acc_cnt_q, acc_cnt_d;
    logic                sop_q, sop_d;
    logic [ID_WIDTH-1:0] tlp_rid_q, tlp_rid_d;
    logic [1:0]          tlp_resp_q, tlp_resp_d;
    logic                rvalid_q, rvalid_d;
    logic [DW_W-1:0]     rdata_q, rdata_d;
    logic [ID_WIDTH-1:0] rid_q, rid_d;
    logic [1:0]          rresp_q, rresp_d;
    logic                rlast_q, rlast_d;
    logic                err_len_q, err_len_d;

    logic                out_free;
    logic                cpl_ready;
    logic                len_bad;
    logic [CW-1:0]       total;
    logic [DW_W-1:0]     chunk_m;
    logic [2*DW_W-1:0]   slots;
    logic [ID_WIDTH-1:0] rid_use;
    logic [1:0]          resp_use;
    logic                unused_tag;

    assign unused_tag = ^i_cpl_tag[9:ID_WIDTH];

    function automatic logic [1:0] map_resp(input logic [2:0] st);
        case (st)
            3'b000:  map_resp = 2'b00;
            3'b001:  map_resp = 2'b11;
            default: map_resp = 2'b10;
        endcase
    endfunction

    assign out_free    = !rvalid_q || i_rready;
    assign cpl_ready   = (state_q == ACCUM) && out_free && !i_rst;
    assign o_cpl_ready = cpl_ready;
    assign len_bad     = (i_cpl_valid_data == '0) ||
                         (i_cpl_valid_data > VALID_DATA_WIDTH'(BEAT_DW));
    assign total       = acc_cnt_q + CW'(i_cpl_valid_data);

    always_comb begin
        chunk_m = '0;
        for (int k = 0; k < BEAT_DW; k++) begin
            if (VALID_DATA_WIDTH'(k) < i_cpl_valid_data)
                chunk_m[k*32 +: 32] = i_cpl_data[k*32 +: 32];
        end
        // Held DWs sit in the low slots; the new chunk lands right above them.
        slots = {{DW_W{1'b0}}, acc_data_q} | ({{DW_W{1'b0}}, chunk_m} << {acc_cnt_q, 5'b0});
    end

    always_comb begin
        state_d    = state_q;
        acc_data_d = acc_data_q;
        acc_cnt_d  = acc_cnt_q;
        sop_d      = sop_q;
        tlp_rid_d  = tlp_rid_q;
        tlp_resp_d = tlp_resp_q;
        rvalid_d   = rvalid_q && !i_rready;
        rdata_d    = rdata_q;
        rid_d      = rid_q;
        rresp_d    = rresp_q;
        rlast_d    = rlast_q;
        err_len_d  = 1'b0;
        rid_use    = sop_q ? i_cpl_tag[ID_WIDTH-1:0] : tlp_rid_q;
        resp_use   = sop_q ? map_resp(i_cpl_status) : tlp_resp_q;

        case (state_q)
            ACCUM: begin
                if (i_cpl_valid && cpl_ready) begin
                    if (len_bad) begin
                        err_len_d = 1'b1;
                    end else begin
                        sop_d      = i_cpl_last;
                        tlp_rid_d  = rid_use;
                        tlp_resp_d = resp_use;
                        if (total >= CW'(BEAT_DW)) begin
                            rvalid_d   = 1'b1;
                            rdata_d    = slots[DW_W-1:0];
                            rid_d      = rid_use;
                            rresp_d    = resp_use;
                            rlast_d    = i_cpl_last && (total == CW'(BEAT_DW));
                            acc_data_d = slots[2*DW_W-1:DW_W];
                            acc_cnt_d  = total - CW'(BEAT_DW);
                            if (i_cpl_last && (total > CW'(BEAT_DW)))
                                state_d = FLUSH;
                        end else if (i_cpl_last) begin
                            rvalid_d   = 1'b1;
                            rdata_d    = slots[DW_W-1:0];
                            rid_d      = rid_use;
                            rresp_d    = resp_use;
                            rlast_d    = 1'b1;
                            acc_data_d = '0;
                            acc_cnt_d  = '0;
                        end else begin
                            acc_data_d = slots[DW_W-1:0];
                            acc_cnt_d  = total;
                        end
                    end
                end
            end
            FLUSH: begin
                // Leftover DWs of a finished TLP go out as their own RLAST beat.
                if (out_free) begin
                    rvalid_d   = 1'b1;
                    rdata_d    = acc_data_q;
                    rid_d      = tlp_rid_q;
                    rresp_d    = tlp_resp_q;
                    rlast_d    = 1'b1;
                    acc_data_d = '0;
                    acc_cnt_d  = '0;
                    state_d    = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ACCUM;
            acc_data_q <= '0;
            acc_cnt_q  <= '0;
            sop_q      <= 1'b1;
            tlp_rid_q  <= '0;
            tlp_resp_q <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rid_q      <= '0;
            rresp_q    <= '0;
            rlast_q    <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_data_q <= acc_data_d;
            acc_cnt_q  <= acc_cnt_d;
            sop_q      <= sop_d;
            tlp_rid_q  <= tlp_rid_d;
            tlp_resp_q <= tlp_resp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rid_q      <= rid_d;
            rresp_q    <= rresp_d;
            rlast_q    <= rlast_d;
            err_len_q  <= err_len_d;
        end
    end

    assign o_rvalid  = rvalid_q;
    assign o_rdata   = rdata_q;
    assign o_rid     = rid_q;
    assign o_rresp   = rresp_q;
    assign o_rlast   = rlast_q;
    assign o_err_len = err_len_q;

endmodule

// File: tb/tb_tl_rx_cpl_axi_r_packer.sv
// Directed bench for the completion-to-AXI-R packer with hand-computed beats.
module tb_tl_rx_cpl_axi_r_packer;
    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_cpl_valid = 1'b0;
    logic [4:0]   i_cpl_valid_data = '0;
    logic [255:0] i_cpl_data = '0;
    logic         i_cpl_last = 1'b0;
    logic [9:0]   i_cpl_tag = '0;
    logic [2:0]   i_cpl_status = '0;
    logic         o_cpl_ready;
    logic         o_rvalid;
    logic         i_rready = 1'b1;
    logic [255:0] o_rdata;
    logic [3:0]   o_rid;
    logic [1:0]   o_rresp;
    logic         o_rlast;
    logic         o_err_len;

    int n_cmp = 0;
    int n_err = 0;
    int waited;

    tl_rx_cpl_axi_r_packer #(.BEAT_DW(8), .VALID_DATA_WIDTH(5), .ID_WIDTH(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_cpl_valid(i_cpl_valid), .i_cpl_valid_data(i_cpl_valid_data),
        .i_cpl_data(i_cpl_data), .i_cpl_last(i_cpl_last),
        .i_cpl_tag(i_cpl_tag), .i_cpl_status(i_cpl_status),
        .o_cpl_ready(o_cpl_ready), .o_rvalid(o_rvalid), .i_rready(i_rready),
        .o_rdata(o_rdata), .o_rid(o_rid), .o_rresp(o_rresp),
        .o_rlast(o_rlast), .o_err_len(o_err_len)
    );

    always #5 i_clk = ~i_clk;

    // Payload DW with global index i is 0xC0DE0000+i; lanes past the count carry junk.
    function automatic logic [255:0] mkchunk(input int start, input int n);
        logic [255:0] r;
        for (int k = 0; k < 8; k++)
            r[k*32 +: 32] = (k < n) ? (32'hC0DE0000 + 32'(start + k)) : (32'hBAD00000 + 32'(k));
        return r;
    endfunction

    function automatic logic [255:0] mkbeat(input int start, input int n);
        logic [255:0] r;
        for (int k = 0; k < 8; k++)
            r[k*32 +: 32] = (k < n) ? (32'hC0DE0000 + 32'(start + k)) : 32'h0;
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [255:0] dat, input logic last,
                            input logic [3:0] rid, input logic [1:0] resp);
        check({tag, "_rvalid"}, 256'(o_rvalid), 256'(1));
        check({tag, "_rdata"},  o_rdata, dat);
        check({tag, "_rlast"},  256'(o_rlast), 256'(last));
        check({tag, "_rid"},    256'(o_rid), 256'(rid));
        check({tag, "_rresp"},  256'(o_rresp), 256'(resp));
    endtask

    // Offers one chunk; returns at edge+1 after the accepting edge.
    task automatic push(input int n, input int start, input logic last, input logic [9:0] tag,
                        input logic [2:0] st, output int w);
        i_cpl_valid      = 1'b1;
        i_cpl_valid_data = 5'(n);
        i_cpl_data       = mkchunk(start, n);
        i_cpl_last       = last;
        i_cpl_tag        = tag;
        i_cpl_status     = st;
        w = 0;
        #1;
        while (!o_cpl_ready && w < 30) begin
            @(posedge i_clk); #1;
            w++;
        end
        if (!o_cpl_ready) begin
            check("push_timeout", 256'(o_cpl_ready), 256'(1));
            i_cpl_valid = 1'b0;
        end else begin
            @(posedge i_clk); #1;
            i_cpl_valid = 1'b0;
        end
    endtask

    task automatic idle();
        @(posedge i_clk); #1;
    endtask

    initial begin
        #2;
        check("rst_rvalid", 256'(o_rvalid), 256'(0));
        check("rst_ready",  256'(o_cpl_ready), 256'(0));
        check("rst_rdata",  o_rdata, 256'(0));
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        idle();

        // Two full chunks, tag 5, status SC
        push(8, 0, 1'b0, 10'h005, 3'b000, waited);
        chk_beat("t1_b0", mkbeat(0, 8), 1'b0, 4'h5, 2'b00);
        push(8, 8, 1'b1, 10'h005, 3'b000, waited);
        chk_beat("t1_b1", mkbeat(8, 8), 1'b1, 4'h5, 2'b00);
        idle();
        check("t1_drop", 256'(o_rvalid), 256'(0));

        // 3+3+3+3
        push(3, 0, 1'b0, 10'h006, 3'b000, waited);
        check("t2_nobeat0", 256'(o_rvalid), 256'(0));
        push(3, 3, 1'b0, 10'h006, 3'b000, waited);
        check("t2_nobeat1", 256'(o_rvalid), 256'(0));
        push(3, 6, 1'b0, 10'h006, 3'b000, waited);
        chk_beat("t2_b0", mkbeat(0, 8), 1'b0, 4'h6, 2'b00);
        push(3, 9, 1'b1, 10'h006, 3'b000, waited);
        chk_beat("t2_b1", mkbeat(8, 4), 1'b1, 4'h6, 2'b00);
        idle();

        // 6+6 with flush
        push(6, 0, 1'b0, 10'h009, 3'b000, waited);
        check("t3_nobeat", 256'(o_rvalid), 256'(0));
        push(6, 6, 1'b1, 10'h009, 3'b000, waited);
        chk_beat("t3_b0", mkbeat(0, 8), 1'b0, 4'h9, 2'b00);
        check("t3_flush_rdy", 256'(o_cpl_ready), 256'(0));
        idle();
        chk_beat("t3_b1", mkbeat(8, 4), 1'b1, 4'h9, 2'b00);
        check("t3_rdy_back", 256'(o_cpl_ready), 256'(1));
        idle();

        // RREADY backpressure
        i_rready = 1'b0;
        push(8, 0, 1'b1, 10'h002, 3'b000, waited);
        for (int c = 0; c < 5; c++) begin
            idle();
            check("t4_hold_rdy", 256'(o_cpl_ready), 256'(0));
            chk_beat("t4_hold", mkbeat(0, 8), 1'b1, 4'h2, 2'b00);
        end
        i_rready = 1'b1;
        push(8, 8, 1'b1, 10'h003, 3'b000, waited);
        check("t4_no_bubble", 256'(waited), 256'(0));
        chk_beat("t4_next", mkbeat(8, 8), 1'b1, 4'h3, 2'b00);
        idle();

        // Illegal counts mid-TLP, status UR
        push(2, 0, 1'b0, 10'h03A, 3'b001, waited);
        push(0, 50, 1'b0, 10'h011, 3'b000, waited);
        check("t5_err0", 256'(o_err_len), 256'(1));
        check("t5_err0_nobeat", 256'(o_rvalid), 256'(0));
        push(9, 60, 1'b1, 10'h011, 3'b000, waited);
        check("t5_err9", 256'(o_err_len), 256'(1));
        check("t5_err9_nobeat", 256'(o_rvalid), 256'(0));
        push(8, 2, 1'b0, 10'h011, 3'b000, waited);
        check("t5_err_clr", 256'(o_err_len), 256'(0));
        chk_beat("t5_b0", mkbeat(0, 8), 1'b0, 4'hA, 2'b11);
        push(1, 10, 1'b1, 10'h011, 3'b000, waited);
        chk_beat("t5_b1", mkbeat(8, 3), 1'b1, 4'hA, 2'b11);
        idle();

        // Reset while flushing
        push(6, 0, 1'b0, 10'h001, 3'b000, waited);
        push(6, 6, 1'b1, 10'h001, 3'b000, waited);
        i_rst = 1'b1;
        #1;
        check("t6_rvalid", 256'(o_rvalid), 256'(0));
        check("t6_rdata",  o_rdata, 256'(0));
        check("t6_rlast",  256'(o_rlast), 256'(0));
        check("t6_rid",    256'(o_rid), 256'(0));
        check("t6_ready",  256'(o_cpl_ready), 256'(0));
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        idle();
        check("t6_quiet", 256'(o_rvalid), 256'(0));
        push(1, 20, 1'b1, 10'h3C7, 3'b100, waited);
        chk_beat("t6_b0", mkbeat(20, 1), 1'b1, 4'h7, 2'b10);
        idle();
        check("t6_no_stale", 256'(o_rvalid), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end
endmodule
